// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1-style asynchronous serial receiver.
// Recovers bytes, BREAK frames and framing errors from uart_rxd.
module uart_rx_deframer #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    uart_rx_en,
    input  logic                    uart_rxd,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_break,
    output logic                    uart_rx_frame_err
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CW = $clog2(CYCLES_PER_BIT) + 1;

    // Mid-bit point of the start bit, end point of a full bit period.
    localparam logic [CW-1:0] HALF = CW'(CYCLES_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sync1;
    logic rxs;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0] bit_idx;
    logic [2:0] bit_nxt;

    logic [PAYLOAD_BITS-1:0] shift;
    logic [PAYLOAD_BITS-1:0] shift_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;

    logic valid_nxt;
    logic break_nxt;
    logic ferr_nxt;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit-period cycle counter and data bit index.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Receive shift register, filled LSB-first.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            shift <= '0;
        end else begin
            shift <= shift_nxt;
        end
    end

    // Registered outputs: held data word plus one-cycle status pulses.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_break     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            uart_rx_data      <= data_nxt;
            uart_rx_valid     <= valid_nxt;
            uart_rx_break     <= break_nxt;
            uart_rx_frame_err <= ferr_nxt;
        end
    end

    // Next-state, counter and output decode for the frame sequencer.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        data_nxt  = uart_rx_data;
        valid_nxt = 1'b0;
        break_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (uart_rx_en && !rxs) begin
                    state_nxt = START;
                end
            end

            START: begin
                if (cnt == HALF) begin
                    cnt_nxt = '0;
                    bit_nxt = '0;
                    if (!rxs) begin
                        state_nxt = DATA;
                    end else begin
                        // Line came back high: a glitch, not a start bit.
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            DATA: begin
                if (cnt == LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rxs, shift[PAYLOAD_BITS-1:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            STOP: begin
                if (cnt == LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        // A low stop bit with all-zero data is a BREAK.
                        if (shift == '0) begin
                            break_nxt = 1'b1;
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                        state_nxt = BREAK_WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            BREAK_WAIT: begin
                cnt_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed + random frames against a
// frame-level reference model of the receiver.
module tb_uart_rx_deframer;

    localparam int C = 10;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       uart_rx_break;
    logic       uart_rx_frame_err;

    uart_rx_deframer #(
        .CLK_HZ(1000000),
        .BIT_RATE(100000),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .uart_rx_en(uart_rx_en),
        .uart_rxd(uart_rxd),
        .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_break(uart_rx_break),
        .uart_rx_frame_err(uart_rx_frame_err)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int n_valid = 0;
    int n_break = 0;
    int n_ferr = 0;
    int n_wide = 0;
    int n_excl = 0;
    int valid_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_data [0:63];

    always @(negedge clk_in) begin
        if (uart_rx_valid === 1'b1) begin
            if (n_valid < 64) got_data[n_valid] <= uart_rx_data;
            n_valid <= n_valid + 1;
            valid_cyc <= cyc;
        end
        if (uart_rx_break === 1'b1) n_break <= n_break + 1;
        if (uart_rx_frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if (uart_rx_valid === 1'b1 && prev_valid === 1'b1)
            n_wide <= n_wide + 1;
        if ($countones({uart_rx_valid, uart_rx_break,
                        uart_rx_frame_err}) > 1)
            n_excl <= n_excl + 1;
        prev_valid <= uart_rx_valid;
    end

    // Reference model state: what the line carried, frame by frame.
    int ev = 0;
    int eb = 0;
    int ef = 0;
    int chk_idx = 0;
    logic [7:0] exp_data [0:63];
    logic [7:0] last_data = 8'h00;

    int total = 0;
    int bad = 0;
    int fall_cyc = 0;
    int lat = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stopbit);
        if (stopbit) begin
            if (ev < 64) exp_data[ev] = b;
            ev++;
            last_data = b;
        end else if (b == 8'h00) begin
            eb++;
        end else begin
            ef++;
        end
    endtask

    // Drives start, 8 data bits LSB-first, stop, then an idle gap.
    // drop_en_bit >= 0 deasserts the enable at that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stopbit,
                              input int gap, input int drop_en_bit);
        logic [9:0] fr;
        fr = {stopbit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == drop_en_bit + 1) uart_rx_en = 1'b0;
            if (i == 0) fall_cyc = cyc;
            uart_rxd = fr[i];
            ticks(C);
        end
        uart_rxd = 1'b1;
        ticks(gap);
    endtask

    task automatic check_all(input string tag);
        ticks(3);
        chk({tag, "_valid_cnt"}, n_valid, ev);
        chk({tag, "_break_cnt"}, n_break, eb);
        chk({tag, "_ferr_cnt"}, n_ferr, ef);
        chk({tag, "_wide_pulse"}, n_wide, 0);
        chk({tag, "_overlap"}, n_excl, 0);
        for (int i = chk_idx; i < ev && i < n_valid && i < 64; i++)
            chk({tag, "_data"}, got_data[i], exp_data[i]);
        chk_idx = ev;
        chk({tag, "_held"}, uart_rx_data, last_data);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        logic rs;
        int rg;
        logic [9:0] fr;

        // Reset and quiet line.
        rst = 1'b1;
        uart_rxd = 1'b1;
        ticks(3);
        chk("rst_data", uart_rx_data, 0);
        chk("rst_valid", uart_rx_valid, 0);
        chk("rst_break", uart_rx_break, 0);
        chk("rst_ferr", uart_rx_frame_err, 0);
        rst = 1'b0;
        uart_rx_en = 1'b1;
        ticks(100);
        check_all("reset");

        // Single byte with latency window.
        send_frame(8'hA5, 1'b1, 20, -9);
        model_frame(8'hA5, 1'b1);
        check_all("single");
        lat = valid_cyc - fall_cyc - 1;
        chk("latency_in_window", (lat >= 97 && lat <= 99) ? 1 : 0, 1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 0, -9);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1, 0, -9);
        model_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1, 20, -9);
        model_frame(8'h3C, 1'b1);
        check_all("b2b");

        // Short low glitch, then a real frame.
        uart_rxd = 1'b0;
        ticks(3);
        uart_rxd = 1'b1;
        ticks(20);
        check_all("glitch");
        send_frame(8'h5A, 1'b1, 20, -9);
        model_frame(8'h5A, 1'b1);
        check_all("after_glitch");

        // Line held low for 30 bit times.
        uart_rxd = 1'b0;
        ticks(30 * C);
        uart_rxd = 1'b1;
        ticks(20);
        eb++;
        check_all("break");
        send_frame(8'h81, 1'b1, 20, -9);
        model_frame(8'h81, 1'b1);
        check_all("after_break");

        // Disabled receiver ignores a frame; mid-frame disable completes.
        uart_rx_en = 1'b0;
        send_frame(8'h6E, 1'b1, 20, -9);
        check_all("disabled");
        uart_rx_en = 1'b1;
        send_frame(8'hC3, 1'b1, 20, 3);
        model_frame(8'hC3, 1'b1);
        uart_rx_en = 1'b1;
        check_all("en_drop");

        // Random frames: random data, stop bit and gaps.
        for (int k = 0; k < 12; k++) begin
            rb = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rg = $urandom_range(0, 15);
            if (!rs) rg = rg + C;
            send_frame(rb, rs, rg, -9);
            model_frame(rb, rs);
        end
        ticks(20);
        check_all("random");

        // Framing error, then recovery.
        send_frame(8'h12, 1'b0, C + 5, -9);
        model_frame(8'h12, 1'b0);
        check_all("ferr");
        send_frame(8'h34, 1'b1, 20, -9);
        model_frame(8'h34, 1'b1);
        check_all("after_ferr");

        // Reset asserted during the data bits of a 0xF0 frame.
        fr = {1'b1, 8'hF0, 1'b0};
        for (int t = 0; t < 10 * C; t++) begin
            uart_rxd = fr[t / C];
            if (t == 2 * C + 5) begin
                rst = 1'b1;
                #1;
                chk("rstmid_data", uart_rx_data, 0);
                chk("rstmid_valid", uart_rx_valid, 0);
                chk("rstmid_break", uart_rx_break, 0);
                chk("rstmid_ferr", uart_rx_frame_err, 0);
            end
            if (t == 5 * C + 5) rst = 1'b0;
            ticks(1);
        end
        uart_rxd = 1'b1;
        last_data = 8'h00;
        ticks(40);
        check_all("rst_mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
